uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between N byte requesters (debug console, status reporter, etc.) using round-robin arbitration.
- Latches the granted byte and drives the serializer's start/data inputs, then waits for its done pulse.
- Runs a timeout watchdog per frame and inserts a programmable idle gap between frames.
- Sits between the requesters and the single uart_tx instance on the TX pin.

Parameters:
N, 2, number of requesters (1..8)
BITS, 8, data width per byte; must match the serializer
TIMEOUT, 1200, max cycles in WAIT before abort (> 10*clks_per_bit of the serializer)
GAP_CYCLES, 2, idle cycles enforced after each frame (0 allowed)

Ports:
i_wb_clk  in  1  clock
i_wb_rst  in  1  asynchronous active-high reset
i_req  in  N  per-requester request level; held until o_ack seen
i_dat  in  N*BITS  requester k byte at [k*BITS +: BITS]
o_ack  out  N  one-cycle pulse: byte of requester k latched
o_done  out  N  one-cycle pulse: requester k frame finished (or aborted)
o_tx_active  out  1  start strobe to serializer
o_tx_dat  out  BITS  byte to serializer, stable from grant until frame end
i_tx_done  in  1  serializer done pulse
o_busy  out  1  high whenever state != IDLE
o_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE; o_ack=0, o_done=0, o_tx_active=0, o_tx_dat=0, o_busy=0, o_err=0.
  - RR pointer last=N-1, so requester 0 has first priority.
  - Counters cleared.
- States: IDLE, START, WAIT, GAP. All outputs registered.
- IDLE:
  - If any i_req: choose g = first set bit searching last+1, last+2, ... modulo N.
  - At the edge: latch o_tx_dat<=i_dat[g], grant<=g, last<=g, o_ack[g]<=1, go START.
  - Else stay IDLE.
- START:
  - o_tx_active=1 for exactly this one cycle (set on IDLE->START edge, cleared on START->WAIT edge).
  - Counter cleared; go WAIT.
- WAIT:
  - o_tx_active=0.
  - Counter increments each cycle.
  - If i_tx_done=1: o_done[grant] pulses next cycle, go GAP.
  - Else if counter==TIMEOUT-1: o_err<=1, o_done[grant] pulses, go GAP.
  - If i_tx_done and timeout occur in the same cycle, done wins (no error).
- GAP:
  - Count GAP_CYCLES cycles, then go IDLE.
  - If GAP_CYCLES==0, WAIT exits directly to IDLE.
- o_tx_dat holds its value from the grant edge until the next grant. The serializer resamples data during its start bit, so the value must not change mid-frame.
- Requesters: drop i_req, or present the next byte, on the cycle o_ack is seen. The arbiter samples i_req only in IDLE.
- Requests arriving during START/WAIT/GAP wait; none are lost while i_req stays high.
- i_tx_done outside WAIT is ignored.
- N==1: pointer logic degenerates; requester 0 is always granted.
- Fairness: with all requesters held high, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 frames.
- Latency: i_req rise in IDLE -> o_ack 1 cycle -> o_tx_active the same cycle as o_ack.
- Throughput: one frame per (frame time + 2 + GAP_CYCLES) cycles.

Test Plan:
- Single request: req0=1, dat0=0xA5 -> o_ack=01 and o_tx_active=1 together, 1 cycle after req. o_tx_dat=0xA5. With the serializer at clks_per_bit=104, o_done=01 one cycle after i_tx_done. Line shows 0,1,0,1,0,0,1,0,1,1 (LSB first).
- Contention: req0=req1=1 held, dat0=0x11, dat1=0x22 for 4 frames -> bytes transmitted in order 0x11,0x22,0x11,0x22. GAP_CYCLES=2 idle cycles between each done and the next o_tx_active.
- Pointer rotation: after reset, grant req1 alone, then raise req0 and req1 together -> req0 granted first.
- Timeout: hold i_tx_done=0, TIMEOUT=50 -> o_done pulses exactly 50 cycles after WAIT entry. o_err=1 and stays 1. The next request is still served.
- Done/timeout collision: i_tx_done asserted on cycle TIMEOUT-1 of WAIT -> o_done pulses, o_err stays 0.
- Reset mid-WAIT: assert i_wb_rst asynchronously (not on a clock edge) -> all outputs 0 immediately. After release, req0=1 is granted first; a stale i_tx_done while in IDLE is ignored.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx serializer between N byte requesters using round-robin
// arbitration. A granted byte is latched and handed to the serializer with a
// one-cycle start strobe. The arbiter then waits for the serializer's done
// pulse, with a watchdog that aborts a frame that never completes. It then
// holds the line idle for a programmable gap before the next grant.
//
// Ports:
//   i_wb_clk     clock
//   i_wb_rst     asynchronous active-high reset
//   i_req        [N]       per-requester request level, held until o_ack
//   i_dat        [N*BITS]  requester k byte at [k*BITS +: BITS]
//   o_ack        [N]       one-cycle pulse: byte of requester k latched
//   o_done       [N]       one-cycle pulse: requester k frame finished/aborted
//   o_tx_active  start strobe to the serializer (one cycle per frame)
//   o_tx_dat     [BITS]    byte to the serializer, stable from grant to grant
//   i_tx_done    serializer done pulse (only honoured while waiting)
//   o_busy       high whenever the arbiter is not idle
//   o_err        sticky frame-timeout flag, cleared only by reset
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N          = 2,
    parameter int BITS       = 8,
    parameter int TIMEOUT    = 1200,
    parameter int GAP_CYCLES = 2
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst,
    input  logic [N-1:0]      i_req,
    input  logic [N*BITS-1:0] i_dat,
    output logic [N-1:0]      o_ack,
    output logic [N-1:0]      o_done,
    output logic              o_tx_active,
    output logic [BITS-1:0]   o_tx_dat,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_err
);

    localparam int PW      = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [PW-1:0] LAST_RST     = PW'(N - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // With no gap configured, a finished frame returns straight to IDLE.
    localparam state_t AFTER_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t            state_reg, state_next;
    logic [PW-1:0]     last_reg, last_next;
    logic [PW-1:0]     grant_reg, grant_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [N-1:0]      ack_reg, ack_next;
    logic [N-1:0]      done_reg, done_next;
    logic              tx_active_reg, tx_active_next;
    logic [BITS-1:0]   tx_dat_reg, tx_dat_next;
    logic              busy_reg, busy_next;
    logic              err_reg, err_next;

    // Unpack the flat data bus into one byte per requester.
    logic [BITS-1:0] dat_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign dat_arr[gi] = i_dat[gi*BITS +: BITS];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin pick: first requester set, searching last+1, last+2, ...
    // wrapping modulo N. The last candidate visited is 'last' itself, so a
    // lone requester is always served again.
    // ------------------------------------------------------------------------
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW:0]   cand;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last_reg} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!pick_valid && i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle after the deciding edge.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        grant_next     = grant_reg;
        cnt_next       = cnt_reg;
        ack_next       = '0;
        done_next      = '0;
        tx_active_next = 1'b0;
        tx_dat_next    = tx_dat_reg;
        err_next       = err_reg;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    tx_dat_next         = dat_arr[pick_idx];
                    grant_next          = pick_idx;
                    last_next           = pick_idx;
                    ack_next[pick_idx]  = 1'b1;
                    tx_active_next      = 1'b1;
                    state_next          = START;
                end
            end

            START: begin
                cnt_next   = '0;
                state_next = WAIT;
            end

            WAIT: begin
                cnt_next = cnt_reg + 1'b1;
                // A real done takes priority over a simultaneous timeout.
                if (i_tx_done) begin
                    done_next[grant_reg] = 1'b1;
                    cnt_next             = '0;
                    state_next           = AFTER_WAIT;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    done_next[grant_reg] = 1'b1;
                    err_next             = 1'b1;
                    cnt_next             = '0;
                    state_next           = AFTER_WAIT;
                end
            end

            GAP: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Registered version of (state != IDLE).
        busy_next = (state_next != IDLE);
    end

    // ------------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_reg     <= IDLE;
            last_reg      <= LAST_RST;
            grant_reg     <= '0;
            cnt_reg       <= '0;
            ack_reg       <= '0;
            done_reg      <= '0;
            tx_active_reg <= 1'b0;
            tx_dat_reg    <= '0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            grant_reg     <= grant_next;
            cnt_reg       <= cnt_next;
            ack_reg       <= ack_next;
            done_reg      <= done_next;
            tx_active_reg <= tx_active_next;
            tx_dat_reg    <= tx_dat_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    assign o_ack       = ack_reg;
    assign o_done      = done_reg;
    assign o_tx_active = tx_active_reg;
    assign o_tx_dat    = tx_dat_reg;
    assign o_busy      = busy_reg;
    assign o_err       = err_reg;

endmodule
